seven_seg_mux: RTL and testbench
================================

# seven_seg_mux

Parametrised, time-multiplexed seven-segment display driver for the board's common-anode digit banks. Scans `NUM_DIGITS` hex digits, with per-digit decimal points, a hexadecimal or decimal glyph mode, and leading-zero suppression. A 4-bit PWM brightness control sets the on-time. A double-buffered load port means a new value is only shown at a frame boundary, so a digit never changes partway through a scan. The block sits between the status/score logic and the board pins, and replaces the fixed three-digit scan driver.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned. Range 2..8.
- `DIV_BITS`, 14: each digit slot lasts 2^DIV_BITS clocks. Range 4..24.
- `ACTIVE_LOW`, 1: 1 means `seg`, `dp_out` and `an` are active-low; 0 inverts all three.
- `clk` in 1: system clock. All state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `value` in 4*NUM_DIGITS: digit nibbles. `value[3:0]` is digit 0, the rightmost and least significant digit.
- `dp` in NUM_DIGITS: decimal-point request, one bit per digit.
- `load` in 1: single-cycle strobe that captures `value`/`dp` into the shadow register.
- `hex_mode` in 1: 1 means nibbles 10..15 render A,b,C,d,E,F. 0 means those nibbles render blank segments.
- `lz_blank` in 1: 1 enables leading-zero suppression.
- `brightness` in 4: PWM duty, in sixteenths. 0 means dark.
- `seg` out 7: segments {g,f,e,d,c,b,a}. Registered.
- `dp_out` out 1: decimal-point segment. Registered.
- `an` out NUM_DIGITS: digit enables, one-hot active. Registered.
- `frame_done` out 1: one-cycle pulse each time the scan wraps from digit NUM_DIGITS-1 to digit 0.

## Operation
- **Divider:** `cnt` is a DIV_BITS-bit free-running counter. The slot ends when `cnt` is all ones, and at that point `idx` increments.
- **Digit index:** `idx` counts 0..NUM_DIGITS-1. When a slot ends at `idx`=NUM_DIGITS-1, `idx` wraps to 0; this is the frame boundary.
- **Shadow register:** when `load`=1, the shadow register takes `value`/`dp` and a `pending` flag is set.
- **Display register:**
  - At a frame boundary with `pending`=1, the display register takes the shadow contents and `pending` clears.
  - If `load` occurs in the same cycle as a boundary, the incoming `value`/`dp` goes directly into the display register and `pending` stays 0.
  - A second `load` before the boundary overwrites the shadow register; the last one wins.
- **Glyphs** (active-low, before ACTIVE_LOW inversion): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. Blank is 1111111.
- **Leading-zero suppression:**
  - With `lz_blank`=1, digit i (i≥1) is suppressed when its nibble and every nibble above it are zero.
  - Digit 0 is never suppressed.
  - A suppressed digit has its anode off and `dp_out` off, even if its `dp` bit is set.
- **PWM:** the current anode is on only while `cnt[DIV_BITS-1:DIV_BITS-4]` < `brightness`. When the anode is off, `seg` and `dp_out` also read as off, which avoids ghosting.
- **Polarity:** with ACTIVE_LOW=1, "on" means 0 on the pin. With ACTIVE_LOW=0, all output levels are inverted.

## Timing
- **Reset** (asynchronous, takes effect immediately on `rst_n` low): `cnt`=0, `idx`=0, shadow/display registers=0, `pending`=0.
  - Outputs with ACTIVE_LOW=1: `an`=all 1, `seg`=7'h7F, `dp_out`=1, `frame_done`=0.
  - With ACTIVE_LOW=0, the levels are inverted.
- **Output latency:** `seg`/`dp_out`/`an` reflect the (`cnt`,`idx`) state of the previous cycle, i.e. a fixed 1-cycle latency. `frame_done` is asserted in the cycle after the wrap edge.
- **Frame length:** a frame is NUM_DIGITS·2^DIV_BITS clocks, so `frame_done` has exactly that period.
- **Visibility of loads:** a load reaches the pins no earlier than the first cycle of the next frame.
- **Anode switching:** anodes are never enabled for two digits in the same cycle, and there are no idle cycles between slots.
- **Reset release:** the first slot is digit 0 with `cnt` starting at 0. The first `frame_done` occurs NUM_DIGITS·2^DIV_BITS cycles after reset release.

## Test plan
Unless stated otherwise, all scenarios use NUM_DIGITS=4, DIV_BITS=4, ACTIVE_LOW=1.

1. **Reset values:** hold `rst_n`=0 for 5 clocks. Required: `an`=4'b1111, `seg`=7'h7F, `dp_out`=1, `frame_done`=0. Then assert `rst_n` low asynchronously in the middle of a slot. Required: the same values appear before the next clock edge.
2. **Basic scan:** `load` 16'h1234 with `dp`=4'b0100, `brightness`=15, `hex_mode`=1.
   - After the next boundary, the digit 0 slot shows `an`=1110 and `seg`=0011001 for 15 cycles, then `an`=1111 for 1 cycle.
   - Digit 2 shows `seg`=0100100 with `dp_out`=0.
   - `frame_done` pulses every 64 cycles.
3. **Glyph modes:** `value`=16'h00AF.
   - With `hex_mode`=1, `lz_blank`=1: digits 3 and 2 keep `an` high throughout their slots; digit 1 shows 0001000 and digit 0 shows 0001110.
   - With `hex_mode`=0: digits 1 and 0 show `seg`=1111111.
   - With `value`=16'h0000 and `lz_blank`=1: only digit 0 is lit, showing 1000000.
4. **Tear-free update:**
   - Display 16'h1111, then `load` 16'h2222 during the digit 1 slot and `load` 16'h3333 during the digit 2 slot. Required: digits 2 and 3 still show 1 for the rest of that frame; the next frame shows 3 on all digits.
   - `load` coincident with the boundary cycle. Required: takes effect in that same next frame.
5. **Brightness:** `brightness`=0 → `an`=1111 for an entire frame. `brightness`=8 → each anode is low for exactly 8 consecutive cycles per 16-cycle slot.
6. **Polarity and width:** with ACTIVE_LOW=0 and NUM_DIGITS=6, `load` 24'h000005. Required: reset `an`=6'b000000; only `an[0]`=1 with `seg`=7'b1101101; frame period is 96 cycles.

Source files
------------

// File: rtl/seven_seg_mux.sv
// Time-multiplexed seven-segment driver with PWM dimming, leading-zero blanking and a
// double-buffered load port so digits only change at frame boundaries.
module seven_seg_mux #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DIV_BITS   = 14,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    hex_mode,
    input  logic                    lz_blank,
    input  logic [3:0]              brightness,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned     IdxW    = $clog2(NUM_DIGITS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);
    localparam logic            Inv     = !ACTIVE_LOW;

    logic [DIV_BITS-1:0]     cnt_q;
    logic [IdxW-1:0]         idx_q;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, disp_val_q;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, disp_dp_q;
    logic                    pending_q;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q;

    logic                    slot_end, wrap;
    logic [NUM_DIGITS-1:0]   suppress;
    logic [3:0]              nibble;
    logic                    dp_sel, supp_sel, lit;
    logic [6:0]              glyph, glyph_shown;

    assign slot_end = &cnt_q;
    assign wrap     = slot_end && (idx_q == LastIdx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_BITS'(1);
            if (slot_end) begin
                idx_q <= wrap ? '0 : idx_q + IdxW'(1);
            end
        end
    end

    // A load landing on the wrap edge bypasses the shadow so it is not held back a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            pending_q    <= 1'b0;
        end else if (load) begin
            shadow_val_q <= value;
            shadow_dp_q  <= dp;
            if (wrap) begin
                disp_val_q <= value;
                disp_dp_q  <= dp;
                pending_q  <= 1'b0;
            end else begin
                pending_q  <= 1'b1;
            end
        end else if (wrap && pending_q) begin
            disp_val_q <= shadow_val_q;
            disp_dp_q  <= shadow_dp_q;
            pending_q  <= 1'b0;
        end
    end

    // A digit is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        suppress   = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_above  = zero_above && (disp_val_q[4*i +: 4] == 4'h0);
            suppress[i] = lz_blank && (i != 0) && zero_above;
        end
    end

    always_comb begin
        nibble   = 4'h0;
        dp_sel   = 1'b0;
        supp_sel = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IdxW'(i)) begin
                nibble   = disp_val_q[4*i +: 4];
                dp_sel   = disp_dp_q[i];
                supp_sel = suppress[i];
            end
        end
    end

    always_comb begin
        glyph = 7'h7F;
        unique case (nibble)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            4'hF: glyph = 7'b0001110;
        endcase
    end

    assign glyph_shown = (!hex_mode && nibble > 4'd9) ? 7'h7F : glyph;
    assign lit         = (cnt_q[DIV_BITS-1 -: 4] < brightness) && !supp_sel;

    // Segments and DP are forced off whenever the anode is off to avoid ghosting.
    always_comb begin
        seg_d = (lit ? glyph_shown : 7'h7F) ^ {7{Inv}};
        dp_d  = (lit ? ~dp_sel : 1'b1) ^ Inv;
        an_d  = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            an_d[i] = !(lit && (idx_q == IdxW'(i))) ^ Inv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q        <= {7{ACTIVE_LOW}};
            dp_q         <= ACTIVE_LOW;
            an_q         <= {NUM_DIGITS{ACTIVE_LOW}};
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= wrap;
        end
    end

    assign seg        = seg_q;
    assign dp_out     = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Directed bench for seven_seg_mux: 4-digit active-low instance plus a 6-digit
// active-high instance; expected pin states are queued and compared at their slot.
module tb_seven_seg_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load, hex_mode, lz_blank;
    logic [3:0]  brightness;
    logic [6:0]  seg;
    logic        dp_out, frame_done;
    logic [3:0]  an;

    logic [23:0] value2 = 24'h000005;
    logic [5:0]  dp2 = 6'b0;
    logic [6:0]  seg2;
    logic        dp_out2, frame_done2;
    logic [5:0]  an2;

    always #5 clk = ~clk;

    seven_seg_mux #(.NUM_DIGITS(4), .DIV_BITS(4), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .load(load),
        .hex_mode(hex_mode), .lz_blank(lz_blank), .brightness(brightness),
        .seg(seg), .dp_out(dp_out), .an(an), .frame_done(frame_done)
    );

    seven_seg_mux #(.NUM_DIGITS(6), .DIV_BITS(4), .ACTIVE_LOW(1'b0)) dut6 (
        .clk(clk), .rst_n(rst_n), .value(value2), .dp(dp2), .load(load),
        .hex_mode(hex_mode), .lz_blank(lz_blank), .brightness(brightness),
        .seg(seg2), .dp_out(dp_out2), .an(an2), .frame_done(frame_done2)
    );

    typedef struct {
        string      tag;
        int         at;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   pos = 0;  // negedges since the last frame_done sample

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        pos++;
    endtask

    task automatic sync_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 300);
        cmp("sync_frame_done", frame_done, 1);
        pos = 0;
    endtask

    task automatic expect_at(input string tag, input int d, input int k, input logic [3:0] a,
                             input logic [6:0] s, input logic p);
        exp_t e;
        e.tag = tag;
        e.at  = 1 + d * 16 + k;
        e.an  = a;
        e.seg = s;
        e.dp  = p;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (pos < e.at) tick();
            cmp({e.tag, "_an"}, an, e.an);
            cmp({e.tag, "_seg"}, seg, e.seg);
            cmp({e.tag, "_dp"}, dp_out, e.dp);
        end
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp    = d;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    initial begin
        int n, lit_cnt, first, last;
        logic [3:0] an_exp;

        rst_n = 1'b0; value = '0; dp = '0; load = 1'b0;
        hex_mode = 1'b1; lz_blank = 1'b0; brightness = 4'd15;
        repeat (5) @(negedge clk);
        cmp("rst_an", an, 4'b1111);
        cmp("rst_seg", seg, 7'h7F);
        cmp("rst_dp", dp_out, 1'b1);
        cmp("rst_fd", frame_done, 1'b0);
        cmp("rst6_an", an2, 6'b000000);
        cmp("rst6_seg", seg2, 7'h00);
        cmp("rst6_dp", dp_out2, 1'b0);

        // First frame_done lands a full frame after reset release.
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 200);
        cmp("first_fd_latency", n, 64);
        pos = 0;
        expect_at("idle_d0", 0, 3, 4'b1110, 7'b1000000, 1'b1);
        expect_at("idle_d1", 1, 5, 4'b1101, 7'b1000000, 1'b1);
        drain();

        // Asynchronous reset mid-slot, checked before the next rising edge.
        while (pos < 1 + 16 + 8) tick();
        #2 rst_n = 1'b0;
        #1;
        cmp("async_an", an, 4'b1111);
        cmp("async_seg", seg, 7'h7F);
        cmp("async_dp", dp_out, 1'b1);
        cmp("async_fd", frame_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic scan.
        pulse_load(16'h1234, 4'b0100);
        sync_frame();
        expect_at("scan_d0_k0", 0, 0, 4'b1110, 7'b0011001, 1'b1);
        expect_at("scan_d0_k14", 0, 14, 4'b1110, 7'b0011001, 1'b1);
        expect_at("scan_d0_k15", 0, 15, 4'b1111, 7'h7F, 1'b1);
        expect_at("scan_d1", 1, 0, 4'b1101, 7'b0110000, 1'b1);
        expect_at("scan_d2", 2, 7, 4'b1011, 7'b0100100, 1'b0);
        expect_at("scan_d3", 3, 2, 4'b0111, 7'b1111001, 1'b1);
        drain();
        sync_frame();
        tick();
        cmp("fd_one_cycle", frame_done, 1'b0);
        n = 1;
        while (frame_done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        cmp("fd_period", n, 64);

        // Glyph modes and leading-zero suppression (dp on a suppressed digit stays off).
        lz_blank = 1'b1;
        pulse_load(16'h00AF, 4'b1000);
        sync_frame();
        expect_at("hex_d0", 0, 3, 4'b1110, 7'b0001110, 1'b1);
        expect_at("hex_d1", 1, 3, 4'b1101, 7'b0001000, 1'b1);
        expect_at("lz_d2", 2, 8, 4'b1111, 7'h7F, 1'b1);
        expect_at("lz_d3", 3, 0, 4'b1111, 7'h7F, 1'b1);
        drain();
        hex_mode = 1'b0;
        sync_frame();
        expect_at("dec_d0", 0, 3, 4'b1110, 7'h7F, 1'b1);
        expect_at("dec_d1", 1, 3, 4'b1101, 7'h7F, 1'b1);
        drain();
        hex_mode = 1'b1;
        pulse_load(16'h0000, 4'b0000);
        sync_frame();
        expect_at("zero_d0", 0, 3, 4'b1110, 7'b1000000, 1'b1);
        expect_at("zero_d1", 1, 3, 4'b1111, 7'h7F, 1'b1);
        expect_at("zero_d3", 3, 3, 4'b1111, 7'h7F, 1'b1);
        drain();

        // Tear-free update: mid-frame loads wait for the boundary; last one wins.
        lz_blank = 1'b0;
        pulse_load(16'h1111, 4'b0000);
        sync_frame();
        while (pos < 1 + 16 + 4) tick();
        pulse_load(16'h2222, 4'b0000);
        while (pos < 1 + 32 + 4) tick();
        pulse_load(16'h3333, 4'b0000);
        expect_at("tear_d2", 2, 10, 4'b1011, 7'b1111001, 1'b1);
        expect_at("tear_d3", 3, 3, 4'b0111, 7'b1111001, 1'b1);
        drain();
        sync_frame();
        expect_at("upd_d0", 0, 2, 4'b1110, 7'b0110000, 1'b1);
        expect_at("upd_d3", 3, 12, 4'b0111, 7'b0110000, 1'b1);
        drain();
        // Load on the wrap cycle shows in the frame that starts right after it.
        while (pos < 63) tick();
        pulse_load(16'h4567, 4'b0000);
        cmp("coincide_fd", frame_done, 1'b1);
        pos = 0;
        expect_at("coin_d0", 0, 2, 4'b1110, 7'b1111000, 1'b1);
        expect_at("coin_d1", 1, 2, 4'b1101, 7'b0000010, 1'b1);
        expect_at("coin_d3", 3, 2, 4'b0111, 7'b0011001, 1'b1);
        drain();

        // Brightness.
        brightness = 4'd0;
        sync_frame();
        lit_cnt = 0;
        repeat (64) begin
            tick();
            if (an !== 4'b1111) lit_cnt++;
        end
        cmp("dark_lit_cycles", lit_cnt, 0);
        brightness = 4'd8;
        sync_frame();
        for (int d = 0; d < 4; d += 2) begin
            an_exp  = ~(4'b0001 << d);
            lit_cnt = 0;
            first   = -1;
            last    = -1;
            for (int k = 0; k < 16; k++) begin
                while (pos < 1 + d * 16 + k) tick();
                if (an === an_exp) begin
                    lit_cnt++;
                    if (first < 0) first = k;
                    last = k;
                end
            end
            cmp($sformatf("pwm8_d%0d_count", d), lit_cnt, 8);
            cmp($sformatf("pwm8_d%0d_first", d), first, 0);
            cmp($sformatf("pwm8_d%0d_last", d), last, 7);
        end

        // Six-digit active-high instance.
        brightness = 4'd15;
        lz_blank   = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done2 !== 1'b1 && n < 300);
        cmp("w6_sync", frame_done2, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done2 !== 1'b1 && n < 300);
        cmp("w6_period", n, 96);
        repeat (3) @(negedge clk);
        cmp("w6_d0_an", an2, 6'b000001);
        cmp("w6_d0_seg", seg2, 7'b1101101);
        cmp("w6_d0_dp", dp_out2, 1'b0);
        repeat (48) @(negedge clk);
        cmp("w6_d3_an", an2, 6'b000000);
        cmp("w6_d3_seg", seg2, 7'b0000000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
